// File: rtl/minute_hour_counter_if.sv
// ============================================================================
// Module   : minute_hour_counter_if
// Brief    : Tick/button inputs and time/status outputs of minute_hour_counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface minute_hour_counter_if;
  logic       sec_tick;
  logic [5:0] sec;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] min;
  logic [4:0] hour;
  logic       pm;
  logic [1:0] state;
  logic       day_pulse;
  logic       sec_clr;

  modport slave (
    input  sec_tick, sec, mode_btn, inc_btn,
    output min, hour, pm, state, day_pulse, sec_clr
  );

  modport master (
    output sec_tick, sec, mode_btn, inc_btn,
    input  min, hour, pm, state, day_pulse, sec_clr
  );
endinterface

`default_nettype wire

// File: rtl/minute_hour_counter.sv
// ============================================================================
// Module   : minute_hour_counter
// Brief    : Minute/hour timekeeper with button-driven set mode, 12/24h range.
// Revision : 1.0
// ============================================================================
`default_nettype none

module minute_hour_counter #(
  parameter int HOUR_24 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  minute_hour_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  localparam logic [4:0] HOUR_RST = (HOUR_24 != 0) ? 5'd0 : 5'd12;

  state_e     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       pm_q, pm_d;
  logic       day_q, day_d;
  logic       secclr_q, secclr_d;
  logic       mode_prev_q, inc_prev_q;

  logic       mode_edge, inc_edge, tick_adv;
  logic [4:0] hour_inc;
  logic       pm_inc;
  logic       midnight;

  assign mode_edge = bus.mode_btn & ~mode_prev_q;
  assign inc_edge  = bus.inc_btn  & ~inc_prev_q;
  assign tick_adv  = bus.sec_tick & (bus.sec == 6'd59);

  // Shared hour step for carry and set; midnight means this step lands on day start.
  always_comb begin
    hour_inc = hour_q + 5'd1;
    pm_inc   = pm_q;
    midnight = 1'b0;
    if (HOUR_24 != 0) begin
      if (hour_q == 5'd23) hour_inc = 5'd0;
      pm_inc   = 1'b0;
      midnight = (hour_q == 5'd23);
    end else begin
      if (hour_q == 5'd12) hour_inc = 5'd1;
      if (hour_q == 5'd11) pm_inc = ~pm_q;
      midnight = (hour_q == 5'd11) && pm_q;
    end
  end

  always_comb begin
    min_d    = min_q;
    hour_d   = hour_q;
    pm_d     = pm_q;
    state_d  = state_q;
    day_d    = 1'b0;
    secclr_d = 1'b0;
    case (state_q)
      RUN: begin
        if (tick_adv) begin
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = hour_inc;
            pm_d   = pm_inc;
            day_d  = midnight;
          end else begin
            min_d = min_q + 6'd1;
          end
        end
        if (mode_edge) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (inc_edge) begin
          hour_d = hour_inc;
          pm_d   = pm_inc;
        end
        if (mode_edge) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (inc_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        if (mode_edge) begin
          state_d  = RUN;
          secclr_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Button history resets high so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      min_q       <= 6'd0;
      hour_q      <= HOUR_RST;
      pm_q        <= 1'b0;
      day_q       <= 1'b0;
      secclr_q    <= 1'b0;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      day_q       <= day_d;
      secclr_q    <= secclr_d;
      mode_prev_q <= bus.mode_btn;
      inc_prev_q  <= bus.inc_btn;
    end
  end

  assign bus.min       = min_q;
  assign bus.hour      = hour_q;
  assign bus.pm        = pm_q;
  assign bus.state     = state_q;
  assign bus.day_pulse = day_q;
  assign bus.sec_clr   = secclr_q;

endmodule

`default_nettype wire
